fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register, and feeds the decoded-stage instruction to the control decoder. It consumes the decoder's PCSrc for jumps resolved in ID, accepts branch redirects resolved in EX, and honours stall/flush requests from the hazard unit. No branch delay slot; wrong-path instructions are squashed to a NOP bubble.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  instruction memory address (= PC register)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- stall_if  in  1  hazard unit: hold PC and IF/ID this cycle
- flush_if  in  1  hazard unit: load bubble into IF/ID this cycle
- id_pcsrc  in  2  PCSrc from decoder for the instruction in ID (0 seq, 1 branch, 2 j/jal, 3 jr/jalr)
- id_rs_data  in  32  forwarded rs value in ID (jr/jalr target)
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_branch_target  in  32  branch target from EX
- id_instr  out  32  IF/ID instruction
- id_pc_plus4  out  32  IF/ID PC+4 of that instruction
- id_valid  out  1  IF/ID holds a real (non-bubble) instruction

## Operation
- Reset (rst_n low, asynchronous): PC = RESET_PC, id_instr = 32'h0, id_pc_plus4 = 32'h0, id_valid = 0. Held while rst_n low; first fetch from RESET_PC in the first cycle after release.
- Jump target (ID): id_pcsrc 2 → {id_pc_plus4[31:28], id_instr[25:0], 2'b00}; id_pcsrc 3 → {id_rs_data[31:2], 2'b00}.
- Jump request valid only when id_valid = 1 and id_pcsrc ∈ {2,3}; id_pcsrc 1 ignored here (resolved in EX).
- Per-cycle update, strict priority:
  1. ex_branch_taken: PC ← {ex_branch_target[31:2], 2'b00}; IF/ID ← bubble.
  2. else stall_if: PC and IF/ID hold (flush_if ignored).
  3. else flush_if: PC ← PC+4; IF/ID ← bubble.
  4. else jump request: PC ← jump target; IF/ID ← bubble.
  5. else: PC ← PC+4; IF/ID ← {imem_rdata, PC+4}, id_valid ← 1.
- Bubble = id_instr 32'h0 (sll $0), id_pc_plus4 32'h0, id_valid 0.
- PC+4 is 32-bit modulo arithmetic; 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Redirect targets always word-aligned (bits [1:0] forced 0); no misalignment exception.

## Timing
- imem_addr is the PC register output, no combinational path from any input.
- Fetch-to-ID latency: 1 cycle (instruction at PC in cycle N appears on id_instr in N+1).
- EX branch taken in cycle N: imem_addr = target in N+1, target instruction on id_instr in N+2; penalty 2 bubbles (the ID bubble here, EX bubble owned by ID/EX register).
- ID jump in cycle N: imem_addr = target in N+1; penalty 1 bubble.
- Stall held k cycles: PC and IF/ID frozen k cycles, resume with no lost/duplicate instruction.
- Jump in ID with stall_if high: no redirect until stall drops; id_rs_data sampled in the first unstalled cycle.
- ex_branch_taken with stall_if high: branch wins, stall ignored that cycle.
- rst_n asserted mid-operation: immediate return to reset values, independent of clk.

## Structure
- Shared package: PCSRC_SEQ/BRANCH/JUMP/JR encodings (2'd0..3), NOP_INSTR = 32'h0, default RESET_PC.
- One combinational sub-module next_pc_sel: computes PC+4, jump target and the prioritised next PC plus a bubble flag; fetch_stage holds only the PC and IF/ID registers.

## Test plan
- Reset: rst_n low mid-run → imem_addr = 32'h0040_0000, id_valid = 0, id_instr = 0 immediately; sequential addresses 0040_0000, _0004, _0008 after release.
- j: id_instr = 32'h0810_0010 at id_pc_plus4 32'h0040_0008 → next imem_addr 32'h0040_0040, one bubble in ID.
- jr under stall: id_pcsrc 3, stall_if high 2 cycles, then id_rs_data 32'h0040_0103 → PC frozen 2 cycles, then imem_addr 32'h0040_0100.
- EX branch: ex_branch_taken with target 32'h0040_0200 while stall_if and a jump in ID both asserted → imem_addr 32'h0040_0200, id_valid 0 next cycle.
- flush_if alone → id_valid 0, PC advances by 4; stall_if and flush_if together → full hold.
- Wrap: RESET_PC = 32'hFFFF_FFF8 → imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared encodings and defaults for the instruction-fetch stage.
package fetch_stage_pkg;
  // PCSrc encodings produced by the control decoder
  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_JR     = 2'd3;

  // sll $0,$0,0 -- the bubble instruction
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Redirect targets are always forced to a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational next-PC selection: PC+4, ID jump target and the
// prioritised redirect (EX branch > stall > flush > ID jump > sequential).
module next_pc_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        id_valid,
  input  logic [25:0] id_jidx,
  input  logic [3:0]  id_pc_hi,
  input  logic [1:0]  id_pcsrc,
  input  logic [31:0] id_rs_data,
  input  logic        stall_if,
  input  logic        flush_if,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        bubble,
  output logic        hold
);
  logic        jump_req;
  logic [31:0] jump_target;

  // Jump target from the instruction sitting in ID; branches (PCSrc 1) resolve in EX
  always_comb begin
    jump_req    = id_valid && ((id_pcsrc == PCSRC_JUMP) || (id_pcsrc == PCSRC_JR));
    jump_target = (id_pcsrc == PCSRC_JR) ? word_align(id_rs_data)
                                         : {id_pc_hi, id_jidx, 2'b00};
  end

  // Priority select; a stall holds PC, so a pending jump waits for the unstalled cycle
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    bubble   = 1'b0;
    hold     = 1'b0;
    if (ex_branch_taken) begin
      next_pc = word_align(ex_branch_target);
      bubble  = 1'b1;
    end else if (stall_if) begin
      next_pc = pc;
      hold    = 1'b1;
    end else if (flush_if) begin
      bubble  = 1'b1;
    end else if (jump_req) begin
      next_pc = jump_target;
      bubble  = 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_if,
  input  logic        flush_if,
  input  logic [1:0]  id_pcsrc,
  input  logic [31:0] id_rs_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4, next_pc;
  logic        bubble, hold;

  next_pc_sel u_sel (
    .pc               (pc_q),
    .id_valid         (valid_q),
    .id_jidx          (instr_q[25:0]),
    .id_pc_hi         (pc4_q[31:28]),
    .id_pcsrc         (id_pcsrc),
    .id_rs_data       (id_rs_data),
    .stall_if         (stall_if),
    .flush_if         (flush_if),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .pc_plus4         (pc_plus4),
    .next_pc          (next_pc),
    .bubble           (bubble),
    .hold             (hold)
  );

  // IF/ID next value: hold, squash to bubble, or capture the fetched word
  always_comb begin
    pc_d    = next_pc;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!hold) begin
      if (bubble) begin
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;
  assign id_valid    = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF state,
// a monitor pops and compares on each falling edge.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, w_rst_n;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc_plus4;
  logic        stall_if, flush_if, ex_branch_taken, id_valid;
  logic [1:0]  id_pcsrc;
  logic [31:0] id_rs_data, ex_branch_target;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;
  logic        w_valid;
  logic        w_zero = 1'b0;
  logic [1:0]  w_ps = 2'd0;
  logic [31:0] w_z32 = 32'h0;

  always #5 clk = ~clk;

  // Instruction memory: one j at 0x0040_0004, otherwise an address-tagged word
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a == 32'h0040_0004) ? 32'h0810_0010 : {8'h24, a[23:0]};
  endfunction
  assign imem_rdata = imem(imem_addr);
  assign w_rdata    = imem(w_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_if(stall_if), .flush_if(flush_if), .id_pcsrc(id_pcsrc),
    .id_rs_data(id_rs_data), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall_if(w_zero), .flush_if(w_zero), .id_pcsrc(w_ps),
    .id_rs_data(w_z32), .ex_branch_taken(w_zero),
    .ex_branch_target(w_z32), .id_instr(w_instr),
    .id_pc_plus4(w_pc4), .id_valid(w_valid)
  );

  typedef struct {
    logic [31:0] addr, instr, pc4;
    logic        vld, wrap;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  event ev_sample;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: compare the oldest expectation against the selected DUT
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or ev_sample);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.wrap) begin
          chk({e.name, ".addr"},  w_addr,  e.addr);
          chk({e.name, ".instr"}, w_instr, e.instr);
          chk({e.name, ".pc4"},   w_pc4,   e.pc4);
          chk({e.name, ".vld"},   {31'b0, w_valid}, {31'b0, e.vld});
        end else begin
          chk({e.name, ".addr"},  imem_addr,   e.addr);
          chk({e.name, ".instr"}, id_instr,    e.instr);
          chk({e.name, ".pc4"},   id_pc_plus4, e.pc4);
          chk({e.name, ".vld"},   {31'b0, id_valid}, {31'b0, e.vld});
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                      input logic v, input logic w, input string nm);
    exp_t e;
    e.addr = a; e.instr = i; e.pc4 = p; e.vld = v; e.wrap = w; e.name = nm;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs and record the state expected after the edge
  task automatic cyc(input logic st, input logic fl, input logic ex, input logic [1:0] ps,
                     input logic [31:0] rs, input logic [31:0] tgt,
                     input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic ev, input logic ew, input string nm);
    stall_if = st; flush_if = fl; ex_branch_taken = ex; id_pcsrc = ps;
    id_rs_data = rs; ex_branch_target = tgt;
    push(ea, ei, ep, ev, ew, nm);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; w_rst_n = 1'b0;
    stall_if = 0; flush_if = 0; ex_branch_taken = 0; id_pcsrc = 0;
    id_rs_data = 0; ex_branch_target = 0;
    repeat (2) @(negedge clk);
    #1;
    push(32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, "reset");
    -> ev_sample;
    #1;
    rst_n = 1'b1;
    // sequential fetch, then j (0x0810_0010) resolved in ID
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0004, 32'h2440_0000, 32'h0040_0004, 1, 0, "seq0");
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0008, 32'h0810_0010, 32'h0040_0008, 1, 0, "seq1");
    cyc(0,0,0,2'd2, 0,0, 32'h0040_0040, 32'h0,         32'h0,         0, 0, "j");
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0044, 32'h2440_0040, 32'h0040_0044, 1, 0, "j_tgt");
    // jr under a 2-cycle stall; rs value before release must be ignored
    cyc(1,0,0,2'd3, 32'h1234_5678,0, 32'h0040_0044, 32'h2440_0040, 32'h0040_0044, 1, 0, "jr_stall0");
    cyc(1,0,0,2'd3, 32'h1234_5678,0, 32'h0040_0044, 32'h2440_0040, 32'h0040_0044, 1, 0, "jr_stall1");
    cyc(0,0,0,2'd3, 32'h0040_0103,0, 32'h0040_0100, 32'h0,         32'h0,         0, 0, "jr");
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0104, 32'h2440_0100, 32'h0040_0104, 1, 0, "jr_tgt");
    // EX branch beats stall and ID jump; target low bits dropped
    cyc(1,0,1,2'd2, 0,32'h0040_0203, 32'h0040_0200, 32'h0, 32'h0, 0, 0, "br");
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0204, 32'h2440_0200, 32'h0040_0204, 1, 0, "br_tgt");
    // flush alone, then stall+flush holds
    cyc(0,1,0,2'd0, 0,0, 32'h0040_0208, 32'h0,         32'h0,         0, 0, "flush");
    cyc(0,0,0,2'd0, 0,0, 32'h0040_020C, 32'h2440_0208, 32'h0040_020C, 1, 0, "post_flush");
    cyc(1,1,0,2'd0, 0,0, 32'h0040_020C, 32'h2440_0208, 32'h0040_020C, 1, 0, "stall_flush");
    // PCSrc branch ignored in ID; jump ignored when ID holds a bubble
    cyc(0,0,0,2'd1, 0,0, 32'h0040_0210, 32'h2440_020C, 32'h0040_0210, 1, 0, "pcsrc1");
    cyc(0,1,0,2'd0, 0,0, 32'h0040_0214, 32'h0,         32'h0,         0, 0, "flush2");
    cyc(0,0,0,2'd2, 0,0, 32'h0040_0218, 32'h2440_0214, 32'h0040_0218, 1, 0, "j_invalid");
    // asynchronous reset mid-run, held across an edge, then release
    rst_n = 1'b0;
    #1;
    push(32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, "async_rst");
    -> ev_sample;
    #1;
    push(32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, "rst_held");
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0004, 32'h2440_0000, 32'h0040_0004, 1, 0, "rel0");
    cyc(0,0,0,2'd0, 0,0, 32'h0040_0008, 32'h0810_0010, 32'h0040_0008, 1, 0, "rel1");
    // wrap instance: RESET_PC 0xFFFF_FFF8
    push(32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b1, "wrap_rst");
    -> ev_sample;
    #1;
    w_rst_n = 1'b1;
    cyc(0,0,0,2'd0, 0,0, 32'hFFFF_FFFC, 32'h24FF_FFF8, 32'hFFFF_FFFC, 1, 1, "wrap0");
    cyc(0,0,0,2'd0, 0,0, 32'h0000_0000, 32'h24FF_FFFC, 32'h0000_0000, 1, 1, "wrap1");
    cyc(0,0,0,2'd0, 0,0, 32'h0000_0004, 32'h2400_0000, 32'h0000_0004, 1, 1, "wrap2");
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
